// File: rtl/com_calc.sv
// com_calc: centre-of-mass of the motion-mask pixels in one video frame.
//
// Pixels flagged by valid_in are summed per frame.  An end-of-frame strobe
// (tabulate_in) snapshots the sums and pixel count, clears the accumulators,
// and starts two parallel 32-iteration restoring dividers that produce the
// mean column and row.  Accumulation keeps running while the dividers work,
// so no pixel is ever dropped.
//
// Ports
//   clk_in       sole clock, rising edge
//   rst_in       synchronous active-high reset
//   x_in  [10:0] column of current mask pixel (0..1279)
//   y_in  [9:0]  row of current mask pixel (0..719)
//   valid_in     current pixel is set; accumulate it
//   tabulate_in  one-cycle end-of-frame strobe
//   x_out [10:0] centroid column (held between results)
//   y_out [9:0]  centroid row (held between results)
//   valid_out    one-cycle pulse, x_out/y_out newly valid
module com_calc #(
  parameter int unsigned MIN_PIXELS = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic        valid_in,
  input  logic        tabulate_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        valid_out
);

  localparam int unsigned DIV_CYCLES = 32;
  localparam logic [4:0]  LAST_ITER  = 5'(DIV_CYCLES - 1);
  localparam logic [19:0] MIN_CNT    = 20'(MIN_PIXELS);

  localparam logic ACCUM  = 1'b0;
  localparam logic DIVIDE = 1'b1;

  logic        state;

  // Running per-frame accumulators
  logic [31:0] x_sum;
  logic [31:0] y_sum;
  logic [19:0] count;

  // Accumulator values including the current pixel
  logic [31:0] x_add;
  logic [31:0] y_add;
  logic [19:0] count_add;
  logic        frame_ok;

  // Divider state: quotient registers are loaded with the dividend and
  // shift it out MSB-first while quotient bits shift in at the bottom.
  logic [31:0] x_quo;
  logic [31:0] y_quo;
  logic [19:0] x_rem;
  logic [19:0] y_rem;
  logic [19:0] divisor;
  logic [4:0]  iter;

  logic [20:0] x_trial;
  logic [20:0] y_trial;
  logic        x_ge;
  logic        y_ge;
  logic [19:0] x_rem_next;
  logic [19:0] y_rem_next;
  logic [31:0] x_quo_next;
  logic [31:0] y_quo_next;

  logic        valid_q;

  always_comb begin
    x_add     = x_sum + (valid_in ? {21'd0, x_in} : '0);
    y_add     = y_sum + (valid_in ? {22'd0, y_in} : '0);
    count_add = count + {19'd0, valid_in};
    frame_ok  = (count_add != '0) && (count_add >= MIN_CNT);
  end

  always_comb begin
    x_trial = {x_rem, x_quo[31]};
    y_trial = {y_rem, y_quo[31]};
    x_ge    = x_trial >= {1'b0, divisor};
    y_ge    = y_trial >= {1'b0, divisor};
    // When the trial fits, the difference is below divisor, so the
    // 20-bit modular subtraction is exact.
    x_rem_next = x_ge ? (x_trial[19:0] - divisor) : x_trial[19:0];
    y_rem_next = y_ge ? (y_trial[19:0] - divisor) : y_trial[19:0];
    x_quo_next = {x_quo[30:0], x_ge};
    y_quo_next = {y_quo[30:0], y_ge};
  end

  // Gated so a reset in the would-be result cycle suppresses the pulse.
  assign valid_out = valid_q & ~rst_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= ACCUM;
      x_sum   <= '0;
      y_sum   <= '0;
      count   <= '0;
      x_quo   <= '0;
      y_quo   <= '0;
      x_rem   <= '0;
      y_rem   <= '0;
      divisor <= '0;
      iter    <= '0;
      x_out   <= '0;
      y_out   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      // The closing pixel is folded into the snapshot via x_add/y_add.
      if (state == ACCUM && tabulate_in) begin
        x_sum <= '0;
        y_sum <= '0;
        count <= '0;
      end else begin
        x_sum <= x_add;
        y_sum <= y_add;
        count <= count_add;
      end

      case (state)
        ACCUM: begin
          if (tabulate_in && frame_ok) begin
            state   <= DIVIDE;
            x_quo   <= x_add;
            y_quo   <= y_add;
            divisor <= count_add;
            x_rem   <= '0;
            y_rem   <= '0;
            iter    <= '0;
          end
        end
        DIVIDE: begin
          x_quo <= x_quo_next;
          y_quo <= y_quo_next;
          x_rem <= x_rem_next;
          y_rem <= y_rem_next;
          iter  <= iter + 5'd1;
          if (iter == LAST_ITER) begin
            x_out   <= x_quo_next[10:0];
            y_out   <= y_quo_next[9:0];
            valid_q <= 1'b1;
            state   <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_com_calc.sv
// tb_com_calc: directed self-checking bench for com_calc.
// A second instance with MIN_PIXELS=4 shares all inputs.
module tb_com_calc;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic        valid_in;
  logic        tabulate_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        valid_out;
  logic [10:0] x4_out;
  logic [9:0]  y4_out;
  logic        valid4_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  com_calc dut (
    .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
    .valid_in(valid_in), .tabulate_in(tabulate_in),
    .x_out(x_out), .y_out(y_out), .valid_out(valid_out)
  );

  com_calc #(.MIN_PIXELS(4)) dut4 (
    .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
    .valid_in(valid_in), .tabulate_in(tabulate_in),
    .x_out(x4_out), .y_out(y4_out), .valid_out(valid4_out)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    x_in = 11'(x);
    y_in = 10'(y);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic tab();
    tabulate_in = 1'b1;
    tick();
    tabulate_in = 1'b0;
  endtask

  // Samples valid_out for n cycles (k=1 is the cycle after the tabulate edge).
  task automatic watch(input int n, output int first, output int pulses,
                       output logic [10:0] xo, output logic [9:0] yo);
    first = -1; pulses = 0; xo = '0; yo = '0;
    for (int k = 1; k <= n; k++) begin
      if (valid_out === 1'b1) begin
        if (first < 0) begin first = k; xo = x_out; yo = y_out; end
        pulses++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    int first, pulses;
    logic [10:0] xo;
    logic [9:0]  yo;
    rst_in = 1'b1;
    // Pixel presented during reset must not leak into the first frame
    x_in = 11'd500; y_in = 10'd500; valid_in = 1'b1;
    tick(); tick();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (x_out !== 11'd0) begin failures++; $display("FAIL reset_x got=%0d exp=0", x_out); end
    checks++; if (y_out !== 10'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", y_out); end
    rst_in = 1'b0; valid_in = 1'b0;
    // Empty frame straight out of reset gives nothing
    tab();
    watch(40, first, pulses, xo, yo);
    checks++; if (pulses !== 0) begin failures++; $display("FAIL reset_empty_pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_single();
    int first, pulses;
    logic [10:0] xo;
    logic [9:0]  yo;
    pix(100, 50);
    tab();
    watch(40, first, pulses, xo, yo);
    checks++; if (first !== 33) begin failures++; $display("FAIL single_latency got=%0d exp=33", first); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
    checks++; if (xo !== 11'd100) begin failures++; $display("FAIL single_x got=%0d exp=100", xo); end
    checks++; if (yo !== 10'd50) begin failures++; $display("FAIL single_y got=%0d exp=50", yo); end
    checks++; if (x_out !== 11'd100 || y_out !== 10'd50) begin
      failures++; $display("FAIL single_hold got=%0d/%0d exp=100/50", x_out, y_out); end
  endtask

  task automatic test_floor();
    int first, pulses;
    logic [10:0] xo;
    logic [9:0]  yo;
    pix(0, 0); pix(3, 1); pix(4, 2);
    tab();
    watch(40, first, pulses, xo, yo);
    checks++; if (first !== 33) begin failures++; $display("FAIL floor_latency got=%0d exp=33", first); end
    checks++; if (xo !== 11'd2 || yo !== 10'd1) begin
      failures++; $display("FAIL floor_xy got=%0d/%0d exp=2/1", xo, yo); end
  endtask

  task automatic test_empty();
    int first, pulses;
    logic [10:0] xo;
    logic [9:0]  yo;
    tab();
    watch(40, first, pulses, xo, yo);
    checks++; if (pulses !== 0) begin failures++; $display("FAIL empty_pulses got=%0d exp=0", pulses); end
    checks++; if (x_out !== 11'd2 || y_out !== 10'd1) begin
      failures++; $display("FAIL empty_hold got=%0d/%0d exp=2/1", x_out, y_out); end
  endtask

  task automatic test_back_to_back();
    int first, pulses;
    logic [10:0] xo;
    logic [9:0]  yo;
    // Pixel and tabulate in the same cycle
    x_in = 11'd10; y_in = 10'd10; valid_in = 1'b1; tabulate_in = 1'b1;
    tick();
    valid_in = 1'b0; tabulate_in = 1'b0;
    first = -1; pulses = 0; xo = '0; yo = '0;
    for (int k = 1; k <= 40; k++) begin
      valid_in = 1'b0; tabulate_in = 1'b0;
      if (k == 1) begin x_in = 11'd20; y_in = 10'd20; valid_in = 1'b1; end
      if (k == 2) tabulate_in = 1'b1;  // must be ignored during DIVIDE
      if (valid_out === 1'b1) begin
        if (first < 0) begin first = k; xo = x_out; yo = y_out; end
        pulses++;
      end
      tick();
    end
    valid_in = 1'b0; tabulate_in = 1'b0;
    checks++; if (first !== 33) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=33", first); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL b2b_first_pulses got=%0d exp=1", pulses); end
    checks++; if (xo !== 11'd10 || yo !== 10'd10) begin
      failures++; $display("FAIL b2b_first_xy got=%0d/%0d exp=10/10", xo, yo); end
    tab();
    watch(40, first, pulses, xo, yo);
    checks++; if (first !== 33) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=33", first); end
    checks++; if (xo !== 11'd20 || yo !== 10'd20) begin
      failures++; $display("FAIL b2b_second_xy got=%0d/%0d exp=20/20", xo, yo); end
  endtask

  task automatic test_min_pixels();
    int p1, p4, f4;
    logic [10:0] x4c;
    logic [9:0]  y4c;
    pix(4, 4); pix(8, 8); pix(12, 12);
    tab();
    p1 = 0; p4 = 0;
    for (int k = 1; k <= 40; k++) begin
      if (valid_out === 1'b1) p1++;
      if (valid4_out === 1'b1) p4++;
      tick();
    end
    checks++; if (p1 !== 1 || x_out !== 11'd8 || y_out !== 10'd8) begin
      failures++; $display("FAIL min1_three got=%0d pulses %0d/%0d exp=1 pulse 8/8", p1, x_out, y_out); end
    checks++; if (p4 !== 0) begin failures++; $display("FAIL min4_three_pulses got=%0d exp=0", p4); end
    pix(1, 2); pix(3, 4); pix(5, 6); pix(7, 8);
    tab();
    p4 = 0; f4 = -1; x4c = '0; y4c = '0;
    for (int k = 1; k <= 40; k++) begin
      if (valid4_out === 1'b1) begin
        if (f4 < 0) begin f4 = k; x4c = x4_out; y4c = y4_out; end
        p4++;
      end
      tick();
    end
    checks++; if (f4 !== 33 || p4 !== 1) begin
      failures++; $display("FAIL min4_four_timing got=first %0d pulses %0d exp=33/1", f4, p4); end
    checks++; if (x4c !== 11'd4 || y4c !== 10'd5) begin
      failures++; $display("FAIL min4_four_xy got=%0d/%0d exp=4/5", x4c, y4c); end
  endtask

  task automatic test_boundary();
    int first, pulses;
    logic [10:0] xo;
    logic [9:0]  yo;
    // Top and bottom rows: x mean 639.5, y mean 359.5 -> 639/359
    for (int x = 0; x < 1280; x++) pix(x, 0);
    for (int x = 0; x < 1280; x++) pix(x, 719);
    tab();
    watch(40, first, pulses, xo, yo);
    checks++; if (first !== 33 || xo !== 11'd639 || yo !== 10'd359) begin
      failures++; $display("FAIL rows_xy got=%0d/%0d at %0d exp=639/359 at 33", xo, yo, first); end
    for (int i = 0; i < 300; i++) pix(1279, 719);
    tab();
    watch(40, first, pulses, xo, yo);
    checks++; if (xo !== 11'd1279 || yo !== 10'd719) begin
      failures++; $display("FAIL corner_xy got=%0d/%0d exp=1279/719", xo, yo); end
  endtask

  task automatic test_reset_divide();
    int first, pulses;
    logic [10:0] xo;
    logic [9:0]  yo;
    pix(9, 9);
    tab();
    pulses = 0;
    for (int k = 1; k <= 45; k++) begin
      rst_in = (k == 10) ? 1'b1 : 1'b0;
      #1;
      if (valid_out === 1'b1) pulses++;
      tick();
    end
    rst_in = 1'b0;
    checks++; if (pulses !== 0) begin failures++; $display("FAIL rst_mid_pulses got=%0d exp=0", pulses); end
    checks++; if (x_out !== 11'd0 || y_out !== 10'd0) begin
      failures++; $display("FAIL rst_mid_xy got=%0d/%0d exp=0/0", x_out, y_out); end
    // Reset landing in the would-be result cycle
    pix(7, 3);
    tab();
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      rst_in = (k == 33) ? 1'b1 : 1'b0;
      #1;
      if (valid_out === 1'b1) pulses++;
      tick();
    end
    rst_in = 1'b0;
    checks++; if (pulses !== 0) begin failures++; $display("FAIL rst_out_pulses got=%0d exp=0", pulses); end
    checks++; if (x_out !== 11'd0 || y_out !== 10'd0) begin
      failures++; $display("FAIL rst_out_xy got=%0d/%0d exp=0/0", x_out, y_out); end
    // Next frame after reset: 1002/2=501, 601/2=300
    pix(500, 300); pix(502, 301);
    tab();
    watch(40, first, pulses, xo, yo);
    checks++; if (first !== 33 || xo !== 11'd501 || yo !== 10'd300) begin
      failures++; $display("FAIL rst_next_xy got=%0d/%0d at %0d exp=501/300 at 33", xo, yo, first); end
  endtask

  initial begin
    rst_in = 1'b1; x_in = '0; y_in = '0; valid_in = 1'b0; tabulate_in = 1'b0;
    test_reset();
    test_single();
    test_floor();
    test_empty();
    test_back_to_back();
    test_min_pixels();
    test_boundary();
    test_reset_divide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/com_calc.md
COM_CALC -- requirements
Module: com_calc

Interface
REQ-001 Parameter MIN_PIXELS, default 1: minimum per-frame pixel count for a valid centroid.
REQ-002 Parameter DIV_CYCLES, fixed 32: division iterations; not user-overridable.
REQ-003 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_in  input  1  synchronous, active-high reset.
REQ-005 x_in  input  11  column of current mask pixel, 0..1279.
REQ-006 y_in  input  10  row of current mask pixel, 0..719.
REQ-007 valid_in  input  1  current pixel is set in the motion mask; accumulate it.
REQ-008 tabulate_in  input  1  one-cycle end-of-frame strobe; close frame and compute centroid.
REQ-009 x_out  output  11  centroid column; velocity stage consumes it as x_com.
REQ-010 y_out  output  10  centroid row; velocity stage consumes it as y_com.
REQ-011 valid_out  output  1  one-cycle pulse; x_out/y_out newly valid.

Function
REQ-012 Accumulators SHALL be x_sum 32b, y_sum 32b, count 20b, unsigned; a 1280x720 frame cannot overflow them.
REQ-013 State ACCUM: each cycle with valid_in=1, x_sum+=x_in, y_sum+=y_in, count+=1.
REQ-014 In ACCUM, tabulate_in=1 SHALL snapshot sums/count and clear the accumulators in the same cycle.
REQ-015 If valid_in and tabulate_in coincide in ACCUM, that pixel SHALL be included in the closing frame's snapshot.
REQ-016 If the snapshot count is 0 or below MIN_PIXELS, the block SHALL stay in ACCUM, emit no valid_out, and leave outputs unchanged.
REQ-017 Otherwise the block SHALL enter DIVIDE: two parallel restoring dividers, one quotient bit per cycle, DIV_CYCLES cycles.
REQ-018 Quotients SHALL be floor(x_sum/count) and floor(y_sum/count), truncated to 11 and 10 bits.
REQ-019 Tabulate in cycle T SHALL give valid_out=1 in cycle T+33 exactly, with x_out/y_out updated in that cycle.
REQ-020 After the valid_out cycle the block SHALL return to ACCUM.
REQ-021 valid_out SHALL be high for exactly one cycle per completed division.
REQ-022 x_out/y_out SHALL hold their last value between pulses.
REQ-023 During DIVIDE, valid_in pixels SHALL accumulate into the next frame.
REQ-024 tabulate_in during DIVIDE SHALL be ignored; accumulation continues, merging that frame into the following one.
REQ-025 valid_in SHALL not be back-pressured; no pixel is ever dropped.

Reset
REQ-026 While rst_in=1, the block SHALL clear x_out, y_out, valid_out, accumulators, snapshot and divider registers to 0 and set state to ACCUM.
REQ-027 Reset during DIVIDE SHALL abort the division with no valid_out, including when asserted in the would-be output cycle.
REQ-028 The first frame after reset SHALL start empty, including pixels presented during the reset cycle.

Verification
REQ-029 Single pixel (100,50) then tabulate at T -> valid_out only at T+33; x_out=100, y_out=50.
REQ-030 Pixels (0,0),(3,1),(4,2), tabulate -> sums 7/3, count 3 -> x_out=2, y_out=1 (floor).
REQ-031 Empty frame tabulate -> no valid_out, outputs hold. With MIN_PIXELS=4 and 3 pixels -> no valid_out.
REQ-032 Pixel (10,10) with tabulate in the same cycle, then (20,20) during DIVIDE, then tabulate:
- first result 10/10;
- second result 20/20.
REQ-033 Full 1280x720 frame, all pixels valid -> x_out=639, y_out=359, no overflow.
REQ-034 rst_in asserted at T+10 of a division -> no valid_out, x_out=y_out=0; the next frame computes correctly.
